bram_scan_reader: RTL and testbench
===================================

// Module: bram_scan_reader
// PURPOSE
//  Read-side counterpart of the reset-initialised BRAM: walks addresses 0..DATA_DEPTH-1
//  on one BRAM read port and streams (addr, data) out over a valid/ready interface.
//  Also counts entries equal to MATCH_VALUE (e.g. remaining pellets in the maze map).
//  Sits between the map BRAM's spare port and consumers such as the level-clear
//  logic and the debug/readback path.
// PARAMETERS
//  DATA_WIDTH   4     width of one BRAM word
//  DATA_DEPTH   1023  number of words scanned; need not be a power of two
//  MATCH_VALUE  1     word value counted into match_count (DATA_WIDTH bits)
//  localparam ADDR_W = $clog2(DATA_DEPTH); CNT_W = $clog2(DATA_DEPTH+1)
// PORTS
//  clk          in   1           system clock
//  soft_rst     in   1           synchronous, active-high reset
//  start        in   1           pulse: begin a scan (ignored while busy)
//  busy         out  1           high from accepted start until done
//  done         out  1           one-cycle pulse after the last output handshake
//  rd_addr      out  ADDR_W      BRAM read address (BRAM data returns 1 cycle later)
//  rd_data      in   DATA_WIDTH  BRAM read data
//  out_valid    out  1           stream word valid
//  out_ready    in   1           consumer ready
//  out_addr     out  ADDR_W      address of out_data
//  out_data     out  DATA_WIDTH  BRAM word
//  match_count  out  CNT_W       number of accepted words == MATCH_VALUE in current/last scan
// BEHAVIOUR
//  - Reset (soft_rst=1 at posedge): state=IDLE; busy=0, done=0, out_valid=0, rd_addr=0,
//    match_count=0, skid FIFO and in-flight flag cleared. soft_rst beats start in same cycle.
//  - FSM: IDLE -start-> SCAN (match_count<=0, issue ptr<=0); SCAN -last addr issued-> DRAIN;
//    DRAIN -FIFO empty and nothing in flight-> DONE; DONE -> IDLE (done=1 for exactly this cycle).
//  - Read issue: one read per cycle max, only if fifo_count + inflight < 2 (credit rule);
//    on issue rd_addr<=ptr, inflight<=1, ptr<=ptr+1. Data captured into 2-entry FIFO
//    the cycle after issue with its address. rd_addr holds when not issuing.
//  - Last address is DATA_DEPTH-1; ptr never exceeds it (no wrap to 0 within a scan).
//  - Stream: out_* driven from FIFO head; FIFO pops on out_valid&&out_ready. out_addr/out_data
//    stable while out_valid=1 and out_ready=0. Addresses emitted strictly 0,1,...,DEPTH-1.
//  - Throughput: with out_ready held 1, first out_valid 2 cycles after start; then one
//    word per cycle; done pulses 1 cycle after final handshake.
//  - match_count increments (saturating at DATA_DEPTH) on each handshake with
//    out_data==MATCH_VALUE; holds after done until next accepted start.
//  - start while busy: ignored, no effect on ptr/count. start in DONE cycle: ignored.
//  - soft_rst mid-scan: immediate abort, no done pulse, outputs to reset values.
// STRUCTURE
//  - Shared package pacman_map_pkg: tile code constants (TILE_EMPTY, TILE_WALL,
//    TILE_PELLET, TILE_POWER) used for MATCH_VALUE; scan state enum typedef.
//  - One sub-module: scan_skid_fifo (2-entry, {addr,data} wide, push/pop/count).
//  - BRAM model in bench: 1-cycle registered read, no enable.
// TESTING
//  1 DEPTH=8, BRAM={1,0,1,1,2,1,0,3}, out_ready=1, start -> addrs 0..7 in 8 consecutive
//    cycles, data matches, match_count=4, done one cycle after addr 7 accepted.
//  2 Same, out_ready toggled 1/0 each cycle -> no drops/duplicates, data stable while
//    stalled, match_count=4, never more than 1 read in flight beyond FIFO space.
//  3 out_ready=0 for 20 cycles after start -> exactly 2 reads issued, out_addr=0 held;
//    release -> remaining words stream in order.
//  4 start pulsed again mid-scan (cycle 3) -> ignored; single done, count unchanged.
//  5 soft_rst at cycle 5 of scan -> busy=0, out_valid=0, match_count=0, no done;
//    new start afterwards completes full correct scan.
//  6 DEPTH=1023 all words=MATCH_VALUE, out_ready=1 -> last out_addr=1022,
//    match_count=1023, done asserted ~1025 cycles after start.

Source files
------------

// File: rtl/pacman_map_pkg.sv
// Shared maze-map definitions: tile codes stored in the map BRAM and the
// scan-reader state encoding.
package pacman_map_pkg;

  localparam int unsigned TILE_EMPTY  = 0;
  localparam int unsigned TILE_PELLET = 1;
  localparam int unsigned TILE_WALL   = 2;
  localparam int unsigned TILE_POWER  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/scan_skid_fifo.sv
// Two-entry skid FIFO holding {addr, data} pairs returned by the BRAM.
// Simultaneous push and pop are allowed at any occupancy of 1 or 2.
module scan_skid_fifo
  import pacman_map_pkg::*;
#(
  parameter int unsigned WIDTH = 14
) (
  input  logic             i_clk,
  input  logic             i_soft_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;

  always_ff @(posedge i_clk) begin
    if (i_soft_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_din;
          else                 r_tail <= i_din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/bram_scan_reader.sv
// Walks BRAM addresses 0..DATA_DEPTH-1 on one read port, streams (addr, data)
// over valid/ready and counts words equal to MATCH_VALUE.
module bram_scan_reader
  import pacman_map_pkg::*;
#(
  parameter  int unsigned               DATA_WIDTH  = 4,
  parameter  int unsigned               DATA_DEPTH  = 1023,
  parameter  logic [DATA_WIDTH-1:0]     MATCH_VALUE = DATA_WIDTH'(TILE_PELLET),
  localparam int unsigned               ADDR_W      = $clog2(DATA_DEPTH),
  localparam int unsigned               CNT_W       = $clog2(DATA_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  soft_rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      match_count
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DATA_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DATA_DEPTH);

  scan_state_t r_state, w_next;

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_match_count;
  logic [1:0]        w_fifo_count;
  logic [2:0]        w_occ;
  logic              w_pop;
  logic              w_issue;
  logic              w_last;
  logic [ADDR_W+DATA_WIDTH-1:0] w_head;

  assign out_valid = (w_fifo_count != 2'd0);
  assign w_pop     = out_valid && out_ready;
  assign w_last    = (r_ptr == ADDR_LAST);
  assign w_occ     = {1'b0, w_fifo_count} + {2'b00, r_inflight};
  // Credit counts the slot freed by this cycle's pop so a steady stream runs at
  // one word per cycle; the issued address goes straight to the BRAM so its
  // data lands in the FIFO on the following edge.
  assign w_issue   = (r_state == ST_SCAN) && (w_occ < (3'd2 + {2'b00, w_pop}));
  assign rd_addr   = w_issue ? r_ptr : r_rd_addr;

  always_ff @(posedge clk) begin
    if (soft_rst) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_SCAN;
      ST_SCAN: begin
        busy = 1'b1;
        if (w_issue && w_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!r_inflight && ((w_fifo_count == 2'd0) || (w_fifo_count == 2'd1 && w_pop)))
          w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      r_ptr         <= '0;
      r_rd_addr     <= '0;
      r_inflight    <= 1'b0;
      r_match_count <= '0;
    end else begin
      r_inflight <= w_issue;
      if (r_state == ST_IDLE && start) begin
        r_ptr         <= '0;
        r_match_count <= '0;
      end else begin
        if (w_issue) begin
          r_rd_addr <= r_ptr;
          if (!w_last) r_ptr <= r_ptr + ADDR_W'(1);
        end
        if (w_pop && out_data == MATCH_VALUE && r_match_count != CNT_MAX)
          r_match_count <= r_match_count + CNT_W'(1);
      end
    end
  end

  assign match_count = r_match_count;

  scan_skid_fifo #(
    .WIDTH(ADDR_W + DATA_WIDTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_soft_rst (soft_rst),
    .i_push     (r_inflight),
    .i_din      ({r_rd_addr, rd_data}),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_fifo_count)
  );

  assign {out_addr, out_data} = w_head;

endmodule

// File: tb/tb_bram_scan_reader.sv
// Directed bench for bram_scan_reader: an 8-word instance with a cycle table and
// stream sequences, plus a 1023-word instance for the full-depth scan.
module tb_bram_scan_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, ready8, busy8, done8, valid8;
  logic [2:0] rd_addr8, out_addr8;
  logic [3:0] rd_data8, out_data8, mcount8;
  logic [3:0] mem8 [8];

  logic       rst1k, start1k, ready1k, busy1k, done1k, valid1k;
  logic [9:0] rd_addr1k, out_addr1k, mcount1k;
  logic [3:0] rd_data1k, out_data1k;
  logic [3:0] mem1k [1024];

  int checks = 0;
  int errors = 0;

  always @(posedge clk) rd_data8  <= mem8[rd_addr8];
  always @(posedge clk) rd_data1k <= mem1k[rd_addr1k];

  bram_scan_reader #(
    .DATA_WIDTH(4), .DATA_DEPTH(8), .MATCH_VALUE(4'd1)
  ) u_dut8 (
    .clk(clk), .soft_rst(rst8), .start(start8), .busy(busy8), .done(done8),
    .rd_addr(rd_addr8), .rd_data(rd_data8), .out_valid(valid8), .out_ready(ready8),
    .out_addr(out_addr8), .out_data(out_data8), .match_count(mcount8)
  );

  bram_scan_reader #(
    .DATA_WIDTH(4), .DATA_DEPTH(1023), .MATCH_VALUE(4'd1)
  ) u_dut1k (
    .clk(clk), .soft_rst(rst1k), .start(start1k), .busy(busy1k), .done(done1k),
    .rd_addr(rd_addr1k), .rd_data(rd_data1k), .out_valid(valid1k), .out_ready(ready1k),
    .out_addr(out_addr1k), .out_data(out_data1k), .match_count(mcount1k)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        start;
    logic        rdy;
    logic        valid;
    int unsigned addr;
    int unsigned data;
    logic        busy;
    logic        done;
    int unsigned mcnt;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic s, input logic r, input logic v, input int unsigned a,
                              input int unsigned d, input logic b, input logic dn, input int unsigned m);
    vec_t x;
    x.start = s; x.rdy = r; x.valid = v; x.addr = a; x.data = d;
    x.busy = b; x.done = dn; x.mcnt = m;
    return x;
  endfunction

  // mode 0: ready held 1; mode 1: ready toggles; mode 2: ready low for cycles 0..20
  task automatic run8(input int mode, input int restart_at, input int rst_at, input string tag);
    int         n_acc;
    int         dones;
    int         done_cyc;
    logic       stalled;
    logic [2:0] held_a;
    logic [3:0] held_d;
    bit         aborted;
    n_acc = 0; dones = 0; done_cyc = -1; stalled = 1'b0; aborted = 1'b0;
    held_a = '0; held_d = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      start8 = (cyc == 0) || (cyc == restart_at);
      rst8   = (cyc == rst_at);
      case (mode)
        0:       ready8 = 1'b1;
        1:       ready8 = (cyc % 2 == 1);
        default: ready8 = (cyc > 20);
      endcase
      if (stalled) begin
        check({tag, " hold addr"}, 32'(out_addr8), 32'(held_a));
        check({tag, " hold data"}, 32'(out_data8), 32'(held_d));
      end
      stalled = valid8 && !ready8;
      held_a  = out_addr8;
      held_d  = out_data8;
      if (valid8 && ready8) begin
        check({tag, " addr"}, 32'(out_addr8), 32'(n_acc));
        if (n_acc < 8) check({tag, " data"}, 32'(out_data8), 32'(mem8[n_acc]));
        n_acc++;
      end
      tick;
      if (done8) begin
        dones++;
        done_cyc = cyc;
      end
      if (mode == 2 && cyc == 20) begin
        check({tag, " stalled out_addr"}, 32'(out_addr8), 32'd0);
        check({tag, " stalled rd_addr"}, 32'(rd_addr8), 32'd1);
        check({tag, " stalled valid"}, 32'(valid8), 32'd1);
      end
      if (rst8) begin
        aborted = 1'b1;
        break;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start8 = 1'b0;
    rst8   = 1'b0;
    ready8 = 1'b1;
    if (aborted) begin
      check({tag, " abort busy"}, 32'(busy8), 32'd0);
      check({tag, " abort valid"}, 32'(valid8), 32'd0);
      check({tag, " abort mcount"}, 32'(mcount8), 32'd0);
      check({tag, " abort rd_addr"}, 32'(rd_addr8), 32'd0);
      check({tag, " abort done"}, 32'(done8), 32'd0);
      for (int i = 0; i < 6; i++) begin
        tick;
        if (done8) dones++;
      end
      check({tag, " no done after abort"}, 32'(dones), 32'd0);
    end else begin
      check({tag, " words"}, 32'(n_acc), 32'd8);
      check({tag, " done pulses"}, 32'(dones), 32'd1);
      check({tag, " mcount"}, 32'(mcount8), 32'd4);
      check({tag, " busy after"}, 32'(busy8), 32'd0);
      if (mode == 0) check({tag, " done cycle"}, 32'(done_cyc), 32'd10);
    end
  endtask

  initial begin
    int n1k;
    int last1k;
    int order1k;
    int done1k_cyc;

    mem8 = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd2, 4'd1, 4'd0, 4'd3};
    for (int i = 0; i < 1024; i++) mem1k[i] = 4'd1;

    rst8 = 1'b1; start8 = 1'b0; ready8 = 1'b1;
    rst1k = 1'b1; start1k = 1'b0; ready1k = 1'b1;
    repeat (2) tick;
    check("rst busy", 32'(busy8), 32'd0);
    check("rst done", 32'(done8), 32'd0);
    check("rst valid", 32'(valid8), 32'd0);
    check("rst rd_addr", 32'(rd_addr8), 32'd0);
    check("rst mcount", 32'(mcount8), 32'd0);
    check("rst1k busy", 32'(busy1k), 32'd0);
    check("rst1k valid", 32'(valid1k), 32'd0);
    check("rst1k mcount", 32'(mcount1k), 32'd0);
    rst8 = 1'b0;
    rst1k = 1'b0;
    tick;

    // Row r: inputs driven before edge r (edge 0 samples start), outputs checked after it.
    tbl[0]  = mk(1, 1, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 1, 1, 0, 0);
    tbl[3]  = mk(0, 1, 1, 1, 0, 1, 0, 1);
    tbl[4]  = mk(0, 1, 1, 2, 1, 1, 0, 1);
    tbl[5]  = mk(0, 1, 1, 3, 1, 1, 0, 2);
    tbl[6]  = mk(0, 1, 1, 4, 2, 1, 0, 3);
    tbl[7]  = mk(0, 1, 1, 5, 1, 1, 0, 3);
    tbl[8]  = mk(0, 1, 1, 6, 0, 1, 0, 4);
    tbl[9]  = mk(0, 1, 1, 7, 3, 1, 0, 4);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 1, 4);
    tbl[11] = mk(1, 1, 0, 0, 0, 0, 0, 4);

    for (int r = 0; r < 12; r++) begin
      start8 = tbl[r].start;
      ready8 = tbl[r].rdy;
      tick;
      check($sformatf("tbl%0d valid", r), 32'(valid8), 32'(tbl[r].valid));
      check($sformatf("tbl%0d busy", r), 32'(busy8), 32'(tbl[r].busy));
      check($sformatf("tbl%0d done", r), 32'(done8), 32'(tbl[r].done));
      check($sformatf("tbl%0d mcount", r), 32'(mcount8), tbl[r].mcnt);
      if (tbl[r].valid) begin
        check($sformatf("tbl%0d addr", r), 32'(out_addr8), tbl[r].addr);
        check($sformatf("tbl%0d data", r), 32'(out_data8), tbl[r].data);
      end
    end
    start8 = 1'b0;
    tick;
    check("after table busy", 32'(busy8), 32'd0);

    run8(1, -1, -1, "toggle");
    run8(2, -1, -1, "stall");
    run8(0, 3, -1, "restart");
    run8(0, -1, 5, "abort");
    run8(0, -1, -1, "rescan");

    n1k = 0; last1k = -1; order1k = 0; done1k_cyc = -1;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      start1k = (cyc == 0);
      if (valid1k && ready1k) begin
        if (int'(out_addr1k) != n1k || out_data1k != 4'd1) order1k++;
        last1k = int'(out_addr1k);
        n1k++;
      end
      tick;
      if (done1k) begin
        done1k_cyc = cyc;
        break;
      end
    end
    start1k = 1'b0;
    check("1k words", 32'(n1k), 32'd1023);
    check("1k last addr", 32'(last1k), 32'd1022);
    check("1k order errors", 32'(order1k), 32'd0);
    check("1k mcount", 32'(mcount1k), 32'd1023);
    check("1k done cycle", 32'(done1k_cyc), 32'd1025);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
